// File: rtl/trap_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// trap_ctrl_pkg
//  Shared definitions for the machine-mode trap sequencer: CSR addresses,
//  FSM state and sequence-kind encodings, interrupt cause codes, mstatus/mie
//  bit positions and the mstatus update rules for trap entry and MRET.
// -----------------------------------------------------------------------------
package trap_ctrl_pkg;

   // CSR addresses (machine mode)
   localparam logic [11:0] CSR_MSTATUS = 12'h300;
   localparam logic [11:0] CSR_MIE     = 12'h304;
   localparam logic [11:0] CSR_MTVEC   = 12'h305;
   localparam logic [11:0] CSR_MEPC    = 12'h341;
   localparam logic [11:0] CSR_MCAUSE  = 12'h342;
   localparam logic [11:0] CSR_MTVAL   = 12'h343;

   // Interrupt cause codes (mcause[30:0] when mcause[31]=1)
   localparam logic [30:0] CAUSE_MSI = 31'd3;
   localparam logic [30:0] CAUSE_MTI = 31'd7;
   localparam logic [30:0] CAUSE_MEI = 31'd11;

   // mstatus bit positions
   localparam int MSTATUS_MIE    = 3;
   localparam int MSTATUS_MPIE   = 7;
   localparam int MSTATUS_MPP_LO = 11;
   localparam int MSTATUS_MPP_HI = 12;

   // mie enable bit positions
   localparam int MIE_MSIE = 3;
   localparam int MIE_MTIE = 7;
   localparam int MIE_MEIE = 11;

   localparam logic [1:0] MTVEC_MODE_VECTORED = 2'b01;
   localparam logic [1:0] PRV_M               = 2'b11;

   typedef enum logic [3:0] {
      TRAP_S_IDLE,
      TRAP_S_IRQ_CHK,
      TRAP_S_RD_MSTATUS,
      TRAP_S_RD_MTVEC,
      TRAP_S_RD_MEPC,
      TRAP_S_WR_MEPC,
      TRAP_S_WR_MCAUSE,
      TRAP_S_WR_MTVAL,
      TRAP_S_WR_MSTATUS,
      TRAP_S_REDIRECT
   } trap_state_t;

   typedef enum logic {
      TRAP_K_TRAP,
      TRAP_K_MRET
   } trap_kind_t;

   // Trap entry: save MIE into MPIE, disable interrupts, record M-mode in MPP.
   function automatic logic [31:0] mstatus_on_trap(input logic [31:0] ms);
      logic [31:0] r;
      r = ms;
      r[MSTATUS_MPIE]                  = ms[MSTATUS_MIE];
      r[MSTATUS_MIE]                   = 1'b0;
      r[MSTATUS_MPP_HI:MSTATUS_MPP_LO] = PRV_M;
      return r;
   endfunction

   // MRET: restore MIE from MPIE, set MPIE, MPP stays M-mode (M-only core).
   function automatic logic [31:0] mstatus_on_mret(input logic [31:0] ms);
      logic [31:0] r;
      r = ms;
      r[MSTATUS_MIE]                   = ms[MSTATUS_MPIE];
      r[MSTATUS_MPIE]                  = 1'b1;
      r[MSTATUS_MPP_HI:MSTATUS_MPP_LO] = PRV_M;
      return r;
   endfunction

endpackage

// File: rtl/trap_ctrl_irq_prio_enc.sv
// -----------------------------------------------------------------------------
// trap_ctrl_irq_prio_enc
//  Fixed-priority encoder for enabled, pending machine interrupts.
//  Priority: MEI > MSI > MTI.
// Ports
//  pend  in  3   {MEI, MSI, MTI} pending-and-enabled flags
//  valid out 1   at least one interrupt pending
//  code  out 31  cause code of the winning interrupt (0 when none)
// -----------------------------------------------------------------------------
module trap_ctrl_irq_prio_enc
   import trap_ctrl_pkg::*;
(
   input  logic [2:0]  pend,
   output logic        valid,
   output logic [30:0] code
);

   always_comb begin
      valid = |pend;
      code  = '0;
      if (pend[2])      code = CAUSE_MEI;
      else if (pend[1]) code = CAUSE_MSI;
      else if (pend[0]) code = CAUSE_MTI;
   end

endmodule

// File: rtl/trap_ctrl.sv
// -----------------------------------------------------------------------------
// trap_ctrl
//  Machine-mode trap sequencer. On an exception, an enabled interrupt or MRET
//  it stalls the pipeline, reads/updates mepc/mcause/mtval/mstatus one CSR
//  access per cycle, then issues a one-cycle PC redirect.
// Ports
//  clk, rst                      clock, synchronous active-high reset
//  exc_valid/exc_cause/exc_pc/exc_tval   synchronous exception report
//  mret_valid                    MRET executing in EX
//  int_pc                        PC saved to mepc on interrupt
//  irq_ext/irq_sw/irq_timer      level interrupt requests
//  csr_raddr/csr_rdata           private combinational CSR read port
//  csr_we/csr_waddr/csr_wdata    CSR write port
//  stall                         freeze IF/ID/EX while sequencing
//  flush                         one-cycle kill of IF/ID/EX on accept
//  redirect_valid/redirect_pc    one-cycle PC load
// -----------------------------------------------------------------------------
module trap_ctrl
   import trap_ctrl_pkg::*;
#(
   parameter logic [31:0] RESET_VEC = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        exc_valid,
   input  logic [30:0] exc_cause,
   input  logic [31:0] exc_pc,
   input  logic [31:0] exc_tval,
   input  logic        mret_valid,
   input  logic [31:0] int_pc,
   input  logic        irq_ext,
   input  logic        irq_sw,
   input  logic        irq_timer,
   output logic [11:0] csr_raddr,
   input  logic [31:0] csr_rdata,
   output logic        csr_we,
   output logic [11:0] csr_waddr,
   output logic [31:0] csr_wdata,
   output logic        stall,
   output logic        flush,
   output logic        redirect_valid,
   output logic [31:0] redirect_pc
);

   trap_state_t state_q, state_d;
   trap_kind_t  kind_q, kind_d;
   logic [31:0] cause_q, cause_d;
   logic [31:0] epc_q, epc_d;
   logic [31:0] tval_q, tval_d;
   logic [31:0] mstatus_q, mstatus_d;
   logic [31:0] mtvec_q, mtvec_d;
   logic [31:0] target_q, target_d;

   // Interrupt selection; only meaningful in IRQ_CHK, where csr_rdata is mie.
   logic [2:0]  irq_pend;
   logic        irq_valid;
   logic [30:0] irq_code;

   assign irq_pend = {irq_ext   & csr_rdata[MIE_MEIE],
                      irq_sw    & csr_rdata[MIE_MSIE],
                      irq_timer & csr_rdata[MIE_MTIE]};

   trap_ctrl_irq_prio_enc u_prio (
      .pend  (irq_pend),
      .valid (irq_valid),
      .code  (irq_code)
   );

   // Trap target from the latched mtvec. An all-zero mtvec means software
   // never programmed it, so fall back to the reset vector.
   logic [31:0] mtvec_base;
   logic [31:0] trap_pc;

   always_comb begin
      mtvec_base = {mtvec_q[31:2], 2'b00};
      if (mtvec_q == '0)
         trap_pc = RESET_VEC;
      else if (mtvec_q[1:0] == MTVEC_MODE_VECTORED && cause_q[31])
         trap_pc = mtvec_base + {cause_q[29:0], 2'b00};
      else
         trap_pc = mtvec_base;
   end

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples its next value from the same pre-edge snapshot.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= TRAP_S_IDLE;
         kind_q    <= TRAP_K_TRAP;
         cause_q   <= '0;
         epc_q     <= '0;
         tval_q    <= '0;
         mstatus_q <= '0;
         mtvec_q   <= '0;
         target_q  <= '0;
      end else begin
         state_q   <= state_d;
         kind_q    <= kind_d;
         cause_q   <= cause_d;
         epc_q     <= epc_d;
         tval_q    <= tval_d;
         mstatus_q <= mstatus_d;
         mtvec_q   <= mtvec_d;
         target_q  <= target_d;
      end
   end

   always_comb begin
      // NOTE: every output and next-state value gets a default first, so no
      // path through the case below can leave one unassigned (no latches).
      state_d        = state_q;
      kind_d         = kind_q;
      cause_d        = cause_q;
      epc_d          = epc_q;
      tval_d         = tval_q;
      mstatus_d      = mstatus_q;
      mtvec_d        = mtvec_q;
      target_d       = target_q;
      csr_raddr      = CSR_MSTATUS;
      csr_we         = 1'b0;
      csr_waddr      = '0;
      csr_wdata      = '0;
      stall          = (state_q != TRAP_S_IDLE);
      flush          = 1'b0;
      redirect_valid = 1'b0;
      redirect_pc    = '0;

      case (state_q)
         TRAP_S_IDLE: begin
            if (exc_valid) begin
               kind_d  = TRAP_K_TRAP;
               cause_d = {1'b0, exc_cause};
               epc_d   = exc_pc;
               tval_d  = exc_tval;
               flush   = 1'b1;
               state_d = TRAP_S_RD_MSTATUS;
            end else if (mret_valid) begin
               kind_d  = TRAP_K_MRET;
               flush   = 1'b1;
               state_d = TRAP_S_RD_MSTATUS;
            end else if (csr_rdata[MSTATUS_MIE] && (irq_ext || irq_sw || irq_timer)) begin
               state_d = TRAP_S_IRQ_CHK;
            end
         end

         TRAP_S_IRQ_CHK: begin
            csr_raddr = CSR_MIE;
            if (exc_valid) begin
               kind_d  = TRAP_K_TRAP;
               cause_d = {1'b0, exc_cause};
               epc_d   = exc_pc;
               tval_d  = exc_tval;
               flush   = 1'b1;
               state_d = TRAP_S_RD_MSTATUS;
            end else if (irq_valid) begin
               kind_d  = TRAP_K_TRAP;
               cause_d = {1'b1, irq_code};
               epc_d   = int_pc;
               tval_d  = '0;
               flush   = 1'b1;
               state_d = TRAP_S_RD_MSTATUS;
            end else begin
               // Request dropped or not enabled in mie: nothing to take.
               state_d = TRAP_S_IDLE;
            end
         end

         TRAP_S_RD_MSTATUS: begin
            mstatus_d = csr_rdata;
            state_d   = (kind_q == TRAP_K_MRET) ? TRAP_S_RD_MEPC : TRAP_S_RD_MTVEC;
         end

         TRAP_S_RD_MTVEC: begin
            csr_raddr = CSR_MTVEC;
            mtvec_d   = csr_rdata;
            state_d   = TRAP_S_WR_MEPC;
         end

         TRAP_S_RD_MEPC: begin
            csr_raddr = CSR_MEPC;
            target_d  = csr_rdata & ~32'd3;
            state_d   = TRAP_S_WR_MSTATUS;
         end

         // Writes are suppressed in a reset cycle so a reset landing mid
         // sequence commits nothing further to the CSR file.
         TRAP_S_WR_MEPC: begin
            csr_we    = ~rst;
            csr_waddr = CSR_MEPC;
            csr_wdata = {epc_q[31:2], 2'b00};
            state_d   = TRAP_S_WR_MCAUSE;
         end

         TRAP_S_WR_MCAUSE: begin
            csr_we    = ~rst;
            csr_waddr = CSR_MCAUSE;
            csr_wdata = cause_q;
            state_d   = TRAP_S_WR_MTVAL;
         end

         TRAP_S_WR_MTVAL: begin
            csr_we    = ~rst;
            csr_waddr = CSR_MTVAL;
            csr_wdata = tval_q;
            state_d   = TRAP_S_WR_MSTATUS;
         end

         TRAP_S_WR_MSTATUS: begin
            csr_we    = ~rst;
            csr_waddr = CSR_MSTATUS;
            csr_wdata = (kind_q == TRAP_K_MRET) ? mstatus_on_mret(mstatus_q)
                                                : mstatus_on_trap(mstatus_q);
            state_d   = TRAP_S_REDIRECT;
         end

         TRAP_S_REDIRECT: begin
            redirect_valid = 1'b1;
            redirect_pc    = (kind_q == TRAP_K_MRET) ? target_q : trap_pc;
            state_d        = TRAP_S_IDLE;
         end

         default: state_d = TRAP_S_IDLE;
      endcase
   end

endmodule
